// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: instruction formats, opcodes, NOP word,
// and the output FIFO bookkeeping types.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } entry_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer. Immediate range checking is compiled in
// when INSTR_ENCODER_RANGE_CHECK_EN is defined.
module instr_pack
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic illegal;

  // NOTE: every output of a combinational block is defaulted first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    word    = NOP;
    illegal = 1'b0;
    case (fmt_e'(fmt))
      FMT_R:  word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:  word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:  word = {imm[31:12], rd, opcode};
      FMT_UJ: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        word    = NOP;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic fits12, fits13, fits21, range_err;

  // A value fits in N signed bits when bits [31:N-1] are all copies of the sign.
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_S: range_err = ~fits12;
      FMT_SB:       range_err = ~fits13 | imm[0];
      FMT_UJ:       range_err = ~fits21 | imm[0];
      FMT_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end

  assign err = illegal | range_err;
`else
  assign err = illegal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a field set, buffers it in a 2-entry FIFO
// and tags each emitted word with an incrementing address. Optional macro:
// INSTR_ENCODER_RANGE_CHECK_EN (immediate range check inside instr_pack).
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        err
);

  count_e      count_q, count_d;
  entry_t      head_q, tail_q;
  entry_t      new_entry;
  logic [31:0] addr_q;
  logic        push, pop;

  instr_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .word   (new_entry.word),
    .err    (new_entry.err)
  );

  // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case (count_q)
      EMPTY:   if (push) count_d = ONE;
      ONE:     if (push && !pop) count_d = FULL;
               else if (pop && !push) count_d = EMPTY;
      FULL:    if (pop) count_d = ONE;
      default: count_d = EMPTY;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) count_q <= EMPTY;
    else     count_q <= count_d;
  end

  // NOTE: the two storage entries are reset because the head is visible on
  // instr/err and must read as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      addr_q <= BASE_ADDR;
    end else begin
      if (pop) addr_q <= addr_q + 32'd4;
      case (count_q)
        EMPTY: if (push) head_q <= new_entry;
        ONE: begin
          if (push && pop) head_q <= new_entry;
          else if (push)   tail_q <= new_entry;
        end
        FULL:    if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  assign instr      = head_q.word;
  assign err        = head_q.err;
  assign instr_addr = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expected words are
// hand-encoded RV32I values, addresses tracked by a local counter.
module tb_instr_encoder;
  import rv_enc_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr, instr_addr;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_addr;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .instr_addr (instr_addr),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr = BASE;
  endtask

  // Push one field set into an empty FIFO, check the presented word, then pop it.
  task automatic xfer(input string tag, input logic [31:0] want_word, input logic want_err);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".instr"}, instr, want_word);
    check({tag, ".err"},   {31'd0, err}, {31'd0, want_err});
    check({tag, ".addr"},  instr_addr, exp_addr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_addr = exp_addr + 32'd4;
    check({tag, ".drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic range_on;

  initial begin
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    range_on = 1'b1;
`else
    range_on = 1'b0;
`endif
    exp_addr = BASE;
    tick();
    rst = 1'b0;

    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.ready", {31'd0, in_ready}, 32'd1);
    check("rst.instr", instr, 32'd0);
    check("rst.err",   {31'd0, err}, 32'd0);
    check("rst.addr",  instr_addr, BASE);

    set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    xfer("i_addi", 32'h0050_0093, 1'b0);

    do_reset();
    set_fields(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    xfer("s_sw", 32'h0020_A423, 1'b0);
    set_fields(FMT_UJ, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    xfer("uj_jal", 32'h0080_00EF, 1'b0);
    set_fields(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    xfer("u_lui", 32'h1234_52B7, 1'b0);
    set_fields(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    xfer("u_lui_low", 32'h1234_52B7, range_on);
    // Address wraps from FFFF_FFFC to 0 here.
    set_fields(FMT_SB, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    xfer("sb_beq", 32'hFE20_8EE3, 1'b0);
    set_fields(FMT_R, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    xfer("r_add", 32'h0020_81B3, 1'b0);
    set_fields(FMT_R, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    xfer("r_sub", 32'h4020_81B3, 1'b0);
    set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    xfer("i_big", 32'h8000_0093, range_on);
    set_fields(3'd7, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    xfer("fmt7", NOP, 1'b1);
    set_fields(3'd6, OPC_LUI, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    xfer("fmt6", NOP, 1'b1);

    // Backpressure: three offers with out_ready low, only two are captured.
    in_valid = 1'b1;
    set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    check("bp.ready1", {31'd0, in_ready}, 32'd1);
    set_fields(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    check("bp.ready2", {31'd0, in_ready}, 32'd0);
    set_fields(FMT_UJ, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    check("bp.ready3", {31'd0, in_ready}, 32'd0);
    check("bp.hold",   instr, 32'h0050_0093);
    check("bp.haddr",  instr_addr, exp_addr);
    out_ready = 1'b1;
    tick();
    exp_addr = exp_addr + 32'd4;
    check("bp.w1",     instr, 32'h0020_A423);
    check("bp.a1",     instr_addr, exp_addr);
    check("bp.ready4", {31'd0, in_ready}, 32'd1);
    tick();
    exp_addr = exp_addr + 32'd4;
    out_ready = 1'b0;
    check("bp.empty",  {31'd0, out_valid}, 32'd0);
    check("bp.a2",     instr_addr, exp_addr);

    // Simultaneous push and pop while holding one word: new word replaces head.
    set_fields(FMT_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    tick();
    check("pp.head", instr, 32'h0010_0113);
    set_fields(FMT_R, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_addr = exp_addr + 32'd4;
    check("pp.instr", instr, 32'h0020_81B3);
    check("pp.valid", {31'd0, out_valid}, 32'd1);
    check("pp.ready", {31'd0, in_ready}, 32'd1);
    check("pp.addr",  instr_addr, exp_addr);
    tick();
    out_ready = 1'b0;
    check("pp.drain", {31'd0, out_valid}, 32'd0);

    // Reset with the FIFO full; out_ready high on the reset edge must not transfer.
    set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("fr.full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    exp_addr = BASE;
    check("fr.valid", {31'd0, out_valid}, 32'd0);
    check("fr.ready", {31'd0, in_ready}, 32'd1);
    check("fr.addr",  instr_addr, exp_addr);
    check("fr.instr", instr, 32'd0);
    check("fr.err",   {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the address tagged on the first emitted word after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  field set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept a field set.
REQ-006 SHALL have port fmt  input  3  format: 0 R, 1 I, 2 S, 3 SB, 4 U, 5 UJ; 6 and 7 are illegal.
REQ-007 SHALL have port opcode  input  7  opcode field.
REQ-008 SHALL have ports rd, rs1 and rs2, each input 5, register fields.
REQ-009 SHALL have ports funct3 (input 3) and funct7 (input 7), function fields.
REQ-010 SHALL have port imm  input  32  sign-extended immediate value, in byte units for SB and UJ.
REQ-011 SHALL have port out_valid  output  1  encoded word available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the word.
REQ-013 SHALL have port instr  output  32  encoded RV32I instruction word.
REQ-014 SHALL have port instr_addr  output  32  address tag for instr.
REQ-015 SHALL have port err  output  1  encode error flag for the word on instr.

Function
REQ-016 SHALL accept a field set on a rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL transfer a word out on a rising edge where out_valid=1 and out_ready=1.
REQ-018 SHALL pack each format as follows:
- R: funct7|rs2|rs1|funct3|rd|opcode
- I: imm[11:0]|rs1|funct3|rd|opcode
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
- SB: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
- U: imm[31:12]|rd|opcode
- UJ: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
REQ-019 SHALL, for illegal fmt, emit 32'h0000_0013 (NOP) with err=1.
REQ-020 SHALL hold encoded words in a 2-entry FIFO with states EMPTY, ONE and FULL, stored as an occupancy count.
REQ-021 SHALL drive in_ready = (count != FULL), registered-state only, with no combinational path from out_ready.
REQ-022 SHALL drive out_valid = (count != EMPTY).
REQ-023 SHALL present a word accepted at edge N on instr at edge N+1 when the FIFO was EMPTY, giving a latency of 1 cycle.
REQ-024 SHALL emit words in acceptance order.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged; in ONE, the new word replaces the head after the pop.
REQ-026 SHALL hold instr, instr_addr and err stable while out_valid=1 and out_ready=0.
REQ-027 SHALL increment instr_addr by 4 on each output transfer, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-028 SHALL ignore in_valid while the FIFO is FULL; the field set is not captured.

Reset
REQ-029 SHALL, on rst=1 at an edge, force count=EMPTY, out_valid=0, in_ready=1, instr=0, err=0 and instr_addr=BASE_ADDR.
REQ-030 SHALL discard any buffered words when reset occurs mid-operation; no transfer completes on the reset edge.

Configuration
REQ-031 SHALL use macro INSTR_ENCODER_RANGE_CHECK_EN to compile the immediate range check in or out.
REQ-032 SHALL, when INSTR_ENCODER_RANGE_CHECK_EN is defined, set err=1 for any of:
- I or S imm not representable as signed 12-bit;
- SB imm not signed 13-bit, or imm[0]=1;
- UJ imm not signed 21-bit, or imm[0]=1;
- U imm[11:0] != 0.
In each of these cases the word is still packed per REQ-018.
REQ-033 SHALL, when INSTR_ENCODER_RANGE_CHECK_EN is undefined, assert err only for illegal fmt.

Structure
REQ-034 SHALL place in shared package rv_enc_pkg:
- the format enum (R, I, S, SB, U, UJ);
- opcode constants (LOAD, OP_IMM, JALR, STORE, BRANCH, LUI, JAL, OP);
- the NOP constant 32'h0000_0013.
REQ-035 SHALL implement packing and the range check as combinational sub-module instr_pack; the FIFO, handshake and address counter reside in instr_encoder.

Verification
REQ-036 SHALL cover: fmt I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> instr 32'h0050_0093, err=0, instr_addr=BASE_ADDR.
REQ-037 SHALL cover: fmt S, opcode 0100011, funct3=2, rs1=1, rs2=2, imm=8 -> 32'h0020_A423; then fmt UJ, opcode 1101111, rd=1, imm=8 -> 32'h0080_00EF at BASE_ADDR+4.
REQ-038 SHALL cover: fmt U, opcode 0110111, rd=5, imm=32'h1234_5000 -> 32'h1234_52B7; with the macro defined, imm=32'h1234_5001 -> err=1.
REQ-039 SHALL cover: out_ready=0 with three consecutive in_valid -> two accepted, in_ready=0 from the third cycle; raise out_ready -> words emitted in order with instr_addr +4 each.
REQ-040 SHALL cover: fmt=7 -> instr 32'h0000_0013, err=1 (macro defined and undefined).
REQ-041 SHALL cover: rst asserted with the FIFO FULL -> next cycle out_valid=0, in_ready=1, instr_addr=BASE_ADDR.
